byte_cipher_round_ctrl: RTL and testbench

//  Round sequencer for the 8-bit cryptosystem. Accepts one plaintext byte plus key over valid/ready.

---
 rtl/cipher_pkg.sv | 14 +
 rtl/round_key_gen.sv | 12 +
 rtl/byte_cipher_round_ctrl.sv | 103 ++++++++++
 tb/tb_byte_cipher_round_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// cipher_pkg: shared FSM states, round constants and byte rotate for the byte cipher controller.
package cipher_pkg;

    typedef enum logic [2:0] {IDLE, XOR, SUB, FIN, OUT} state_t;

    localparam logic [7:0] RC [0:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    function automatic logic [7:0] rotl8(input logic [7:0] value, input logic [2:0] amount);
        logic [15:0] d;
        d = {value, value} << amount;
        return d[15:8];
    endfunction

endpackage

// File: rtl/round_key_gen.sv
// round_key_gen: per-round key derived from the latched key and the low round index bits.
module round_key_gen
    import cipher_pkg::*;
(
    input  logic [7:0] key_r,
    input  logic [2:0] idx,
    output logic [7:0] rk
);

    assign rk = rotl8(key_r, idx) ^ RC[idx];

endmodule

// File: rtl/byte_cipher_round_ctrl.sv
// byte_cipher_round_ctrl: round sequencer that drives an external combinational 8-bit substitution table.
// Define SEQ_ABORT_EN to add an abort input that cancels an in-flight byte.
module byte_cipher_round_ctrl
    import cipher_pkg::*;
#(
    parameter int NUM_ROUNDS = 4,
    parameter int ROT        = 1
)
(
    input  logic       clk,
    input  logic       rst_n,
`ifdef SEQ_ABORT_EN
    input  logic       abort,
`endif
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [7:0] key,
    output logic [7:0] sbox_addr,
    input  logic [7:0] sbox_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy,
    output logic [7:0] round_idx
);

    localparam logic [7:0] LAST = 8'(NUM_ROUNDS - 1);
    localparam logic [2:0] ROT3 = 3'(ROT);

    state_t     state;
    logic [7:0] st;
    logic [7:0] key_r;
    logic [7:0] rk;
    logic       abort_hit;

    round_key_gen u_rk (
        .key_r (key_r),
        .idx   (round_idx[2:0]),
        .rk    (rk)
    );

`ifdef SEQ_ABORT_EN
    assign abort_hit = abort && (state == XOR || state == SUB || state == FIN);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            st        <= 8'h00;
            key_r     <= 8'h00;
            sbox_addr <= 8'h00;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            round_idx <= 8'h00;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else if (abort_hit) begin
            state     <= IDLE;
            round_idx <= 8'h00;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    st        <= in_data;
                    key_r     <= key;
                    round_idx <= 8'h00;
                    busy      <= 1'b1;
                    in_ready  <= 1'b0;
                    state     <= XOR;
                end
                XOR: begin
                    sbox_addr <= st ^ rk;
                    state     <= SUB;
                end
                SUB: begin
                    st <= rotl8(sbox_data, ROT3);
                    if (round_idx == LAST) state <= FIN;
                    else begin
                        round_idx <= round_idx + 8'd1;
                        state     <= XOR;
                    end
                end
                FIN: begin
                    out_data  <= st ^ key_r;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_cipher_round_ctrl.sv
// tb_byte_cipher_round_ctrl: randomized scoreboard bench with an AES-table sbox and a round-by-round reference model.
module tb_byte_cipher_round_ctrl;

    localparam int NR  = 4;
    localparam int ROT = 1;

    logic [7:0] sbox [0:255] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic       clk = 0, rst_n = 0, abort = 0;
    logic       in_valid = 0, in_ready, out_valid, out_ready = 1, busy;
    logic [7:0] in_data = 0, key = 0, sbox_addr, sbox_data, out_data, round_idx;
    logic       a_valid = 0, a_ready, a_out_valid, a_busy;
    logic [7:0] a_data = 0, a_key = 0, a_addr, a_sdata, a_out, a_round;

    int checks = 0, failures = 0, cyc = 0;
    logic [7:0] exp_q [$];
    int         acc_q [$];
    bit         stall_en = 0, holding = 0;
    logic [7:0] held;

    assign sbox_data = sbox[sbox_addr];
    assign a_sdata   = sbox[a_addr];

    byte_cipher_round_ctrl #(.NUM_ROUNDS(NR), .ROT(ROT)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef SEQ_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .key(key),
        .sbox_addr(sbox_addr), .sbox_data(sbox_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy), .round_idx(round_idx)
    );

    byte_cipher_round_ctrl #(.NUM_ROUNDS(1), .ROT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
`ifdef SEQ_ABORT_EN
        .abort(1'b0),
`endif
        .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data), .key(a_key),
        .sbox_addr(a_addr), .sbox_data(a_sdata), .out_valid(a_out_valid),
        .out_ready(1'b1), .out_data(a_out), .busy(a_busy), .round_idx(a_round)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rl(input int v, input int n);
        return 8'(((v << n) | (v >> (8 - n))) & 255);
    endfunction

    function automatic logic [7:0] model(input logic [7:0] p, input logic [7:0] k);
        logic [7:0] s = p;
        logic [7:0] rk;
        for (int r = 0; r < NR; r++) begin
            rk = rl(int'(k), r % 8) ^ 8'(1 << (r % 8));
            s  = rl(int'(sbox[s ^ rk]), ROT);
        end
        return s ^ k;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [7:0] k, input bit pulse);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1; in_data = d; key = k;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 100) begin chk("accept_timeout", 0, 1); break; end
        end
        exp_q.push_back(model(d, k));
        @(posedge clk); #1;
        in_valid = 0; in_data = 8'($urandom); key = 8'($urandom);
        if (pulse) begin
            @(posedge clk); #1;
            in_valid = 1; in_data = 8'hff; key = 8'hff;
            repeat (3) @(posedge clk);
            #1 in_valid = 0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        chk("drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic run1(input logic [7:0] d, input logic [7:0] k, input logic [7:0] ea, input logic [7:0] eo);
        int t0, n = 0;
        @(posedge clk); #1;
        a_valid = 1; a_data = d; a_key = k;
        @(negedge clk);
        chk("r1_ready", int'(a_ready), 1);
        t0 = cyc;
        @(posedge clk); #1 a_valid = 0;
        @(negedge clk); @(negedge clk);
        chk("r1_sbox_addr", int'(a_addr), int'(ea));
        while (!a_out_valid && n < 20) begin @(negedge clk); n++; end
        chk("r1_latency", cyc - t0, 4);
        chk("r1_out_data", int'(a_out), int'(eo));
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard monitor: stamps accepts, checks latency and data on each new output, then stability while stalled.
    always @(negedge clk) begin
        if (in_valid && in_ready && rst_n) acc_q.push_back(cyc);
        if (out_valid) begin
            if (!holding) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) chk("unexpected_output", int'(out_data), -1);
                else begin
                    chk("latency", cyc - acc_q.pop_front(), 2 * NR + 2);
                    chk("out_data", int'(out_data), int'(exp_q.pop_front()));
                end
                held    = out_data;
                holding = 1;
            end else chk("out_hold", int'(out_data), int'(held));
            if (out_ready) holding = 0;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_en) begin
                out_ready = 0;
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1 out_ready = 1;
            end else out_ready = 1;
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sbox_addr", int'(sbox_addr), 0);
        chk("rst_round_idx", int'(round_idx), 0);
        @(posedge clk); #1 rst_n = 1;

        run1(8'h00, 8'h00, 8'h01, 8'hf8);
        run1(8'h53, 8'h01, 8'h53, 8'hda);

        stall_en = 1;
        for (int i = 0; i < 256; i++) send(8'($urandom), 8'($urandom), 0);
        drain();

        send(8'h3c, 8'ha5, 1);
        drain();

        stall_en = 0;
        send(8'h77, 8'h19, 0);
        n = 0;
        while (round_idx != 8'd2 && n < 30) begin @(negedge clk); n++; end
        chk("reached_round2", int'(round_idx), 2);
        #1 rst_n = 0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_sbox_addr", int'(sbox_addr), 0);
        chk("midrst_round_idx", int'(round_idx), 0);
        exp_q.delete(); acc_q.delete();
        @(posedge clk); #1 rst_n = 1;
        send(8'h00, 8'h00, 0);
        drain();

`ifdef SEQ_ABORT_EN
        send(8'h42, 8'h24, 0);
        @(posedge clk); #1 abort = 1;
        @(posedge clk); #1 abort = 0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_round_idx", int'(round_idx), 0);
        exp_q.delete(); acc_q.delete();
        repeat (15) @(negedge clk);
        chk("abort_no_output", int'(out_valid), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
